// File: rtl/shannon_whitaker_lpfull.sv
// rtl/shannon_whitaker_lpfull.sv - 8-lane sample-parallel 15-tap half-band low-pass FIR
module shannon_whitaker_lpfull #(
    parameter int INBITS = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0][INBITS-1:0] dat_i,
    output logic [7:0][INBITS:0]   dat_o
);
    localparam int PW   = INBITS + 1;
    localparam int ACCW = INBITS + 17;

    localparam logic signed [ACCW-1:0] K1   = ACCW'(10430);
    localparam logic signed [ACCW-1:0] K3   = ACCW'(-3477);
    localparam logic signed [ACCW-1:0] K5   = ACCW'(2086);
    localparam logic signed [ACCW-1:0] K7   = ACCW'(-1490);
    localparam logic signed [ACCW-1:0] RND  = ACCW'(16384);
    localparam logic signed [ACCW-1:0] OMAX = ACCW'((1 << INBITS) - 1);
    localparam logic signed [ACCW-1:0] OMIN = -OMAX - ACCW'(1);

    // hist0 = previous word, hist1 = lanes 1..7 of the word before (lane 0 is never reached)
    logic [7:0][INBITS-1:0] hist0;
    logic [6:0][INBITS-1:0] hist1;

    logic signed [INBITS-1:0] win [0:21];

    logic signed [INBITS-1:0] cen_q [8];
    logic signed [PW-1:0]     p1_q  [8];
    logic signed [PW-1:0]     p3_q  [8];
    logic signed [PW-1:0]     p5_q  [8];
    logic signed [PW-1:0]     p7_q  [8];

    logic signed [ACCW-1:0] mc_q [8];
    logic signed [ACCW-1:0] m1_q [8];
    logic signed [ACCW-1:0] m3_q [8];
    logic signed [ACCW-1:0] m5_q [8];
    logic signed [ACCW-1:0] m7_q [8];

    logic signed [ACCW-1:0] acc [8];
    logic signed [ACCW-1:0] rq  [8];
    logic signed [PW-1:0]   sat [8];

    // Lane k of the word being filtered sits at win[7+k]; its taps span win[k..k+14].
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            win[i]      = hist1[i];
            win[15 + i] = dat_i[i];
        end
        for (int i = 0; i < 8; i++) begin
            win[7 + i] = hist0[i];
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc[k] = mc_q[k] + m1_q[k] + m3_q[k] + m5_q[k] + m7_q[k] + RND;
            rq[k]  = acc[k] >>> 15;
            sat[k] = PW'(rq[k]);
            if (rq[k] > OMAX) begin
                sat[k] = PW'(OMAX);
            end else if (rq[k] < OMIN) begin
                sat[k] = PW'(OMIN);
            end
        end
    end

    // Pipeline: symmetric pre-add, constant multiply, sum/round/clamp.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist0 <= '0;
            hist1 <= '0;
            dat_o <= '0;
            for (int k = 0; k < 8; k++) begin
                cen_q[k] <= '0;
                p1_q[k]  <= '0;
                p3_q[k]  <= '0;
                p5_q[k]  <= '0;
                p7_q[k]  <= '0;
                mc_q[k]  <= '0;
                m1_q[k]  <= '0;
                m3_q[k]  <= '0;
                m5_q[k]  <= '0;
                m7_q[k]  <= '0;
            end
        end else begin
            hist0 <= dat_i;
            hist1 <= hist0[7:1];
            for (int k = 0; k < 8; k++) begin
                cen_q[k] <= win[7 + k];
                p1_q[k]  <= PW'(win[8 + k])  + PW'(win[6 + k]);
                p3_q[k]  <= PW'(win[10 + k]) + PW'(win[4 + k]);
                p5_q[k]  <= PW'(win[12 + k]) + PW'(win[2 + k]);
                p7_q[k]  <= PW'(win[14 + k]) + PW'(win[k]);
                mc_q[k]  <= ACCW'(cen_q[k]) <<< 14;
                m1_q[k]  <= ACCW'(p1_q[k]) * K1;
                m3_q[k]  <= ACCW'(p3_q[k]) * K3;
                m5_q[k]  <= ACCW'(p5_q[k]) * K5;
                m7_q[k]  <= ACCW'(p7_q[k]) * K7;
                dat_o[k] <= sat[k];
            end
        end
    end

endmodule

// File: tb/tb_shannon_whitaker_lpfull.sv
// tb/tb_shannon_whitaker_lpfull.sv - directed bench for the 8-lane half-band FIR
module tb_shannon_whitaker_lpfull;
    localparam int INBITS = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0][INBITS-1:0] dat_i;
    logic [7:0][INBITS:0]   dat_o;

    int checks = 0;
    int errors = 0;

    shannon_whitaker_lpfull #(.INBITS(INBITS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .dat_i(dat_i),
        .dat_o(dat_o)
    );

    always #5 clk = ~clk;

    // Hand-computed response to a single 1000 impulse, indexed by output-minus-impulse offset.
    function automatic int resp(input int d);
        case (d)
            0:       return 500;
            1, -1:   return 318;
            3, -3:   return -106;
            5, -5:   return 64;
            7, -7:   return -45;
            default: return 0;
        endcase
    endfunction

    function automatic longint coef(input int d);
        case (d)
            0:       return 16384;
            1, -1:   return 10430;
            3, -3:   return -3477;
            5, -5:   return 2086;
            7, -7:   return -1490;
            default: return 0;
        endcase
    endfunction

    function automatic int lane_out(input int k);
        logic signed [INBITS:0] v;
        v = dat_o[k];
        return int'(v);
    endfunction

    // Inputs change and outputs are sampled on the falling edge; "clock c" is the c-th falling edge.
    task automatic test_reset();
        int got;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) dat_i[k] = 12'(321 * (k + 1));
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            got = lane_out(k);
            checks++;
            if (got !== 0) begin
                errors++;
                $display("FAIL reset_hold lane %0d: got %0d expected 0", k, got);
            end
        end
        rst = 1'b0;
        dat_i = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                got = lane_out(k);
                checks++;
                if (got !== 0) begin
                    errors++;
                    $display("FAIL post_reset clk %0d lane %0d: got %0d expected 0", c, k, got);
                end
            end
        end
    endtask

    task automatic test_impulse();
        int got, exp;
        @(negedge clk);
        dat_i = '0;
        dat_i[6] = 12'd1000;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dat_i = '0;
            end
            for (int k = 0; k < 8; k++) begin
                got = lane_out(k);
                exp = resp(8 * (c - 4) + k - 6);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL impulse t+%0d lane %0d: got %0d expected %0d", c, k, got, exp);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_impulse_sweep();
        int got, exp;
        for (int lane = 0; lane < 8; lane++) begin
            @(negedge clk);
            dat_i = '0;
            dat_i[lane] = 12'd1000;
            for (int c = 0; c <= 6; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    dat_i = '0;
                end
                for (int k = 0; k < 8; k++) begin
                    got = lane_out(k);
                    exp = resp(8 * (c - 4) + k - lane);
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sweep src %0d t+%0d lane %0d: got %0d expected %0d",
                                 lane, c, k, got, exp);
                    end
                end
            end
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_dc();
        int got;
        @(negedge clk);
        for (int k = 0; k < 8; k++) dat_i[k] = 12'd1000;
        repeat (7) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            got = lane_out(k);
            checks++;
            if (got !== 961) begin
                errors++;
                $display("FAIL dc_pos lane %0d: got %0d expected 961", k, got);
            end
        end
        for (int k = 0; k < 8; k++) dat_i[k] = -12'sd1000;
        repeat (7) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            got = lane_out(k);
            checks++;
            if (got !== -961) begin
                errors++;
                $display("FAIL dc_neg lane %0d: got %0d expected -961", k, got);
            end
        end
        dat_i = '0;
        repeat (8) @(negedge clk);
    endtask

    // Pattern centred on sample 12 (clock 1, lane 4) of a three-word burst.
    task automatic test_worst_case();
        int xs [24];
        int got, exp, aj;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 24; i++) xs[i] = 0;
            for (int j = -7; j <= 7; j++) begin
                aj = (j < 0) ? -j : j;
                if (aj == 0 || aj == 1 || aj == 5) xs[12 + j] = (s == 0) ? 2047 : -2048;
                else if (aj == 3 || aj == 7)       xs[12 + j] = (s == 0) ? -2048 : 2047;
            end
            exp = (s == 0) ? 3208 : -3209;
            @(negedge clk);
            for (int c = 0; c <= 5; c++) begin
                if (c > 0) @(negedge clk);
                for (int k = 0; k < 8; k++) dat_i[k] = (c < 3) ? 12'(xs[8 * c + k]) : 12'd0;
            end
            got = lane_out(4);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL worst_case sign %0d: got %0d expected %0d", s, got, exp);
            end
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int got, exp;
        @(negedge clk);
        dat_i = '0;
        dat_i[6] = 12'd1000;
        @(negedge clk);
        dat_i = '0;
        repeat (2) @(negedge clk);
        got = lane_out(7);
        checks++;
        if (got !== -45) begin
            errors++;
            $display("FAIL mid_reset_pre lane 7: got %0d expected -45", got);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            if (c > 4) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                got = lane_out(k);
                checks++;
                if (got !== 0) begin
                    errors++;
                    $display("FAIL mid_reset_flush t+%0d lane %0d: got %0d expected 0", c, k, got);
                end
            end
        end
        @(negedge clk);
        dat_i = '0;
        dat_i[6] = 12'd1000;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dat_i = '0;
            end
            for (int k = 0; k < 8; k++) begin
                got = lane_out(k);
                exp = resp(8 * (c - 4) + k - 6);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL mid_reset_fresh t+%0d lane %0d: got %0d expected %0d", c, k, got, exp);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    // Rounding is applied once to the combined sum, so expectations use the exact formula.
    task automatic test_two_impulses();
        int got, exp, m;
        longint s;
        @(negedge clk);
        dat_i = '0;
        dat_i[0] = 12'd1000;
        dat_i[2] = 12'd1000;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dat_i = '0;
            end
            for (int k = 0; k < 8; k++) begin
                m   = 8 * (c - 4) + k;
                s   = 1000 * (coef(m) + coef(m - 2)) + 16384;
                exp = int'(s >>> 15);
                got = lane_out(k);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL two_impulses t+%0d lane %0d: got %0d expected %0d", c, k, got, exp);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        dat_i = '0;
        test_reset();
        test_impulse();
        test_impulse_sweep();
        test_dc();
        test_worst_case();
        test_reset_mid();
        test_two_impulses();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
